// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca4_slice.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells.
module rca4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract performed one nibble per clock through a single shared 4-bit adder.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          sub,
    input  logic                          cin,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout,
    output logic                          overflow
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_sr_q, a_sr_d;
    logic [W-1:0]     b_sr_q, b_sr_d;
    logic [W-1:0]     res_q, res_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             a_msb_q, a_msb_d;
    logic             beff_msb_q, beff_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       slice_s;
    logic             slice_co;
    logic [W-1:0]     res_shift;

    rca4_slice u_rca4 (
        .x  (a_sr_q[3:0]),
        .y  (b_sr_q[3:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // New nibble enters at the top; after NIBBLES shifts the LS nibble lands at bit 0.
    assign res_shift = W'({slice_s, res_q} >> NIBBLE_W);

    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        res_d      = res_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        a_msb_d    = a_msb_q;
        beff_msb_d = beff_msb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d     = a;
                    b_sr_d     = sub ? ~b : b;
                    carry_d    = sub | cin;
                    idx_d      = '0;
                    res_d      = '0;
                    a_msb_d    = a[W-1];
                    beff_msb_d = b[W-1] ^ sub;
                    busy_d     = 1'b1;
                    state_d    = ADD;
                end
            end
            ADD: begin
                res_d   = res_shift;
                a_sr_d  = a_sr_q >> NIBBLE_W;
                b_sr_d  = b_sr_q >> NIBBLE_W;
                carry_d = slice_co;
                idx_d   = IDX_W'(idx_q + 1'b1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = res_shift;
                    cout_d  = slice_co;
                    ovf_d   = (a_msb_q == beff_msb_q) && (res_shift[W-1] != a_msb_q);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            a_msb_q    <= 1'b0;
            beff_msb_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            a_msb_q    <= a_msb_d;
            beff_msb_q <= beff_msb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the 16-bit (NIBBLES=4) nibble-serial adder controller.
module tb_nibble_serial_adder_ctrl;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        sub;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge; cycle 1 is the cycle after the accept edge.
    task automatic run_op(input vec_t v, input string tag);
        int          dc;
        logic [15:0] prev;
        prev  = sum;
        dc    = 0;
        sub   = v.sub;
        cin   = v.cin;
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == 2) check($sformatf("%s_busy_mid", tag), 32'(busy), 32'd1);
            if (c == 3) check($sformatf("%s_sum_hold", tag), 32'(sum), 32'(prev));
            if (done) begin
                dc = c;
                break;
            end
        end
        check($sformatf("%s_latency", tag), 32'(dc), 32'd5);
        check($sformatf("%s_busy_done", tag), 32'(busy), 32'd1);
        check($sformatf("%s_sum", tag), 32'(sum), 32'(v.exp_sum));
        check($sformatf("%s_cout", tag), 32'(cout), 32'(v.exp_cout));
        check($sformatf("%s_ovf", tag), 32'(overflow), 32'(v.exp_ovf));
        @(negedge clock);
        check($sformatf("%s_done_1cyc", tag), 32'(done), 32'd0);
        check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        int          ndone;
        int          dcyc[2];
        logic [15:0] dsum;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 16'h1234, 16'h1111, 16'h2346, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

        resetn = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        cin    = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h0000);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
            @(negedge clock);
        end

        // start pulsed during the second ADD cycle must be ignored
        sub   = 1'b0;
        cin   = 1'b0;
        a     = 16'h0001;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clock);
        ndone = 0;
        dsum  = '0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == 2) begin
                a     = 16'hAAAA;
                b     = 16'h1111;
                start = 1'b1;
            end
            if (done) begin
                ndone++;
                dsum = sum;
            end
        end
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_sum", 32'(dsum), 32'h0002);
        check("busy_start_idle", 32'(busy), 32'd0);

        // start held high for 12 cycles: accepts at cycles 0 and 6
        a     = 16'h0003;
        b     = 16'h0004;
        start = 1'b1;
        @(posedge clock);
        ndone   = 0;
        dcyc[0] = 0;
        dcyc[1] = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 12) start = 1'b0;
            if (done) begin
                if (ndone < 2) dcyc[ndone] = c;
                ndone++;
            end
        end
        check("hold_ndone", 32'(ndone), 32'd2);
        check("hold_done0", 32'(dcyc[0]), 32'd5);
        check("hold_done1", 32'(dcyc[1]), 32'd11);
        check("hold_sum", 32'(sum), 32'h0007);

        // async reset in the 3rd ADD cycle
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'h0000);
        @(negedge clock);
        resetn = 1'b1;
        ndone  = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        check("arst_sum_held", 32'(sum), 32'h0000);
        run_op(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
